// File: rtl/div_repeated_sub_if.sv
// Operand/result handshake bundle for the repeated-subtraction divider.
// Latency: none, this is wiring only.
// Backpressure: operands_val/operands_rdy on the way in, result_val/result_rdy on the way out.
//
// Signals (w = operand width):
//   operands_val, operands_rdy, operands_bits_A (dividend), operands_bits_B (divisor)
//   result_val, result_rdy, result_bits_data (quotient), result_bits_rem (remainder)
//   result_bits_divzero: present only when DIV_DIVZERO_FLAG_EN is defined
// Modports: slave = divider side, master = producer/consumer side.
interface div_repeated_sub_if #(
  parameter int w = 16
);
  logic         operands_val;
  logic         operands_rdy;
  logic [w-1:0] operands_bits_A;
  logic [w-1:0] operands_bits_B;
  logic         result_val;
  logic         result_rdy;
  logic [w-1:0] result_bits_data;
  logic [w-1:0] result_bits_rem;
`ifdef DIV_DIVZERO_FLAG_EN
  logic         result_bits_divzero;

  modport slave (
    input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
    output operands_rdy, result_val, result_bits_data, result_bits_rem,
           result_bits_divzero
  );

  modport master (
    output operands_val, operands_bits_A, operands_bits_B, result_rdy,
    input  operands_rdy, result_val, result_bits_data, result_bits_rem,
           result_bits_divzero
  );
`else
  modport slave (
    input  operands_val, operands_bits_A, operands_bits_B, result_rdy,
    output operands_rdy, result_val, result_bits_data, result_bits_rem
  );

  modport master (
    output operands_val, operands_bits_A, operands_bits_B, result_rdy,
    input  operands_rdy, result_val, result_bits_data, result_bits_rem
  );
`endif
endinterface

// File: rtl/div_repeated_sub.sv
// Unsigned divider: quotient and remainder by repeated subtraction of the divisor.
// Latency: q+1 cycles from operand acceptance to result_val (q = quotient); divide-by-zero is 0 cycles.
// Backpressure: single-operation engine; operands accepted only in IDLE, result held in DONE until result_rdy.
//
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any in-flight operation
//   io    : div_repeated_sub_if.slave (operands in, quotient/remainder out)
// Optional feature: DIV_DIVZERO_FLAG_EN adds the registered result_bits_divzero flag.
// Divide-by-zero always returns Q = all-ones and R = A, with or without the flag.
module div_repeated_sub #(
  parameter int w = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  div_repeated_sub_if.slave    io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [w-1:0] r_q;
  logic [w-1:0] d_q;
  logic [w-1:0] q_q;
  logic         operands_rdy_q;
  logic         result_val_q;
`ifdef DIV_DIVZERO_FLAG_EN
  logic         divzero_q;
`endif

  // Handshake outputs are registered copies of the state decode, so they
  // change only on the same edges as state.
  assign io.operands_rdy     = operands_rdy_q;
  assign io.result_val       = result_val_q;
  assign io.result_bits_data = q_q;
  assign io.result_bits_rem  = r_q;
`ifdef DIV_DIVZERO_FLAG_EN
  assign io.result_bits_divzero = divzero_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      r_q            <= '0;
      d_q            <= '0;
      q_q            <= '0;
      operands_rdy_q <= 1'b1;
      result_val_q   <= 1'b0;
`ifdef DIV_DIVZERO_FLAG_EN
      divzero_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // operands_rdy is high throughout IDLE, so val alone completes the handshake.
          if (io.operands_val) begin
            r_q            <= io.operands_bits_A;
            d_q            <= io.operands_bits_B;
            operands_rdy_q <= 1'b0;
`ifdef DIV_DIVZERO_FLAG_EN
            divzero_q      <= (io.operands_bits_B == '0);
`endif
            if (io.operands_bits_B == '0) begin
              // Zero divisor: skip CALC entirely and report all-ones quotient.
              q_q          <= '1;
              state        <= DONE;
              result_val_q <= 1'b1;
            end else begin
              q_q          <= '0;
              state        <= CALC;
            end
          end
        end

        CALC: begin
          // Subtraction is gated by the compare, so R never underflows.
          if (r_q >= d_q) begin
            r_q <= r_q - d_q;
            q_q <= q_q + w'(1);
          end else begin
            state        <= DONE;
            result_val_q <= 1'b1;
          end
        end

        DONE: begin
          if (io.result_rdy) begin
            state          <= IDLE;
            result_val_q   <= 1'b0;
            operands_rdy_q <= 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          operands_rdy_q <= 1'b1;
          result_val_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_repeated_sub.sv
// Directed bench for div_repeated_sub: hand-computed quotient, remainder and latency.
// Latency: n/a (testbench).
// Backpressure: exercises result_rdy stalls and operands presented outside IDLE.
module tb_div_repeated_sub;

  localparam int W = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_repeated_sub_if #(.w(W)) io ();

  div_repeated_sub #(.w(W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present A/B, wait for the result, check latency and values, then consume it.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int exp_lat, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input logic exp_dz);
    int lat;
    int wait_cnt;
    logic rdy_seen;
    wait_cnt = 0;
    while (!io.operands_rdy && wait_cnt < 100) begin
      step();
      wait_cnt++;
    end
    check_val({tag, "_rdy_before"}, io.operands_rdy, 1);
    io.operands_val    = 1'b1;
    io.operands_bits_A = a;
    io.operands_bits_B = b;
    step();                         // edge 0: acceptance
    io.operands_val = 1'b0;
    lat      = 0;
    rdy_seen = io.operands_rdy;
    while (!io.result_val && lat < 70000) begin
      step();
      lat++;
      rdy_seen = rdy_seen | io.operands_rdy;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_rdy_busy"}, rdy_seen, 0);
    check_val({tag, "_q"}, io.result_bits_data, exp_q);
    check_val({tag, "_r"}, io.result_bits_rem, exp_r);
`ifdef DIV_DIVZERO_FLAG_EN
    check_val({tag, "_dz"}, io.result_bits_divzero, exp_dz);
`else
    if (exp_dz === 1'bx) $display("unexpected x divzero request");
`endif
    io.result_rdy = 1'b1;
    step();                         // consumption edge
    io.result_rdy = 1'b0;
    check_val({tag, "_idle_rdy"}, io.operands_rdy, 1);
    check_val({tag, "_idle_val"}, io.result_val, 0);
  endtask

  initial begin
    logic bad;
    checks = 0;
    errors = 0;
    io.operands_val    = 1'b0;
    io.operands_bits_A = '0;
    io.operands_bits_B = '0;
    io.result_rdy      = 1'b0;
    reset              = 1'b1;
    step();
    step();
    check_val("rst_rdy", io.operands_rdy, 1);
    check_val("rst_val", io.result_val, 0);
    check_val("rst_q", io.result_bits_data, 0);
    check_val("rst_r", io.result_bits_rem, 0);
`ifdef DIV_DIVZERO_FLAG_EN
    check_val("rst_dz", io.result_bits_divzero, 0);
`endif
    reset = 1'b0;

    run_op("d17_5", 16'd17, 16'd5, 4, 16'd3, 16'd2, 1'b0);
    run_op("d3_7", 16'd3, 16'd7, 1, 16'd0, 16'd3, 1'b0);
    run_op("d0_9", 16'd0, 16'd9, 1, 16'd0, 16'd0, 1'b0);
    run_op("dffff_1", 16'hFFFF, 16'd1, 65536, 16'hFFFF, 16'd0, 1'b0);
    run_op("d42_0", 16'd42, 16'd0, 0, 16'hFFFF, 16'd42, 1'b1);
    run_op("d10_2", 16'd10, 16'd2, 6, 16'd5, 16'd0, 1'b0);

    // Stall in DONE with new operands offered: result must not move.
    io.operands_val    = 1'b1;
    io.operands_bits_A = 16'd20;
    io.operands_bits_B = 16'd6;
    step();                         // edge 0
    io.operands_bits_A = 16'd99;    // offered outside IDLE, must be ignored
    io.operands_bits_B = 16'd1;
    repeat (4) step();              // q=3 -> DONE at edge 4
    check_val("hold_val_enter", io.result_val, 1);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (io.result_bits_data !== 16'd3 || io.result_bits_rem !== 16'd2 ||
          io.operands_rdy !== 1'b0 || io.result_val !== 1'b1)
        bad = 1'b1;
    end
    check_val("hold_stable", bad, 0);
    io.operands_val = 1'b0;
    io.result_rdy   = 1'b1;
    step();
    io.result_rdy = 1'b0;
    check_val("hold_release_rdy", io.operands_rdy, 1);
    check_val("hold_release_val", io.result_val, 0);

    // Reset mid-CALC discards the operation.
    io.operands_val    = 1'b1;
    io.operands_bits_A = 16'd100;
    io.operands_bits_B = 16'd3;
    step();                         // edge 0
    io.operands_val = 1'b0;
    repeat (4) step();              // edges 1..4
    check_val("mid_val", io.result_val, 0);
    reset = 1'b1;
    step();                         // edge 5 with reset high
    reset = 1'b0;
    check_val("mrst_val", io.result_val, 0);
    check_val("mrst_rdy", io.operands_rdy, 1);
    check_val("mrst_q", io.result_bits_data, 0);
    check_val("mrst_r", io.result_bits_rem, 0);
    run_op("d7_2", 16'd7, 16'd2, 4, 16'd3, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_repeated_sub.md
# div_repeated_sub

Unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse of the team's repeated-addition multiplier. Datapath (remainder/divisor/quotient registers, subtractor, comparator) and control FSM are in one block. Operands and results use val/rdy handshakes.

## Interface
- w, default 16: operand, quotient and remainder width (unsigned).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- operands_val  input  1  operands_bits_A/B valid.
- operands_rdy  output  1  block can accept operands.
- operands_bits_A  input  w  dividend.
- operands_bits_B  input  w  divisor.
- result_val  output  1  result valid.
- result_rdy  input  1  consumer accepts result.
- result_bits_data  output  w  quotient.
- result_bits_rem  output  w  remainder.
- result_bits_divzero  output  1  divisor was zero (present only with DIV_DIVZERO_FLAG_EN).

## Operation
- Registers: R (remainder, w bits), D (divisor, w bits), Q (quotient, w bits), state (2 bits).
- FSM states are IDLE, CALC and DONE.
- Outputs decode from state only (Moore):
  - operands_rdy=1 only in IDLE.
  - result_val=1 only in DONE.
- result_bits_data=Q and result_bits_rem=R in every state.
- IDLE, on operands_val & operands_rdy:
  - Load R<=A, D<=B, Q<=0.
  - Go to CALC if B!=0.
  - If B==0, go to DONE with Q<=all-ones and R<=A (divide-by-zero).
- CALC, each cycle:
  - If R>=D: R<=R-D, Q<=Q+1, stay in CALC.
  - Else go to DONE; R and Q hold.
- DONE: outputs held stable until result_val & result_rdy. On that edge go to IDLE; R, Q and D hold.
- Arithmetic is unsigned, w bits. The compare is a full w-bit magnitude compare. R-D never underflows because it is gated by R>=D. Q cannot overflow, since the maximum quotient is 2^w-1 (A=all-ones, B=1).
- Operands presented outside IDLE are ignored and not consumed.
- Reset in any state, including mid-CALC:
  - State goes to IDLE; R, D and Q clear to 0; the divzero flag clears.
  - Any in-flight operation is discarded and no result is produced.
  - Reset dominates the handshake: no operand acceptance on an edge where reset is high.

## Timing
- Reset values (after the reset edge):
  - operands_rdy=1, result_val=0.
  - result_bits_data=0, result_bits_rem=0, result_bits_divzero=0.
- Call the operand-acceptance edge edge 0 and the final quotient q.
  - Edges 1..q perform the subtractions.
  - Edge q+1 enters DONE.
  - result_val is high from edge q+1, so latency = q+1 cycles.
- Divide-by-zero enters DONE at edge 0 (latency 0 cycles after acceptance).
- Result handshake:
  - Consumption at edge n returns to IDLE, with operands_rdy=1 after edge n.
  - Earliest next acceptance is edge n+1.
  - Throughput is one operation per (q+3) cycles.
- result_rdy asserted before result_val has no effect.

## Configuration
- Macro DIV_DIVZERO_FLAG_EN.
- Defined:
  - Port result_bits_divzero exists and is registered.
  - It is set to 1 on accepting B==0 and to 0 on accepting B!=0.
  - It holds through DONE.
- Undefined:
  - The port and its register are absent.
  - Divide-by-zero behaviour is otherwise identical: Q=all-ones, R=A, immediate DONE.

## Test plan
- Reset, then A=17, B=5 accepted at edge 0 → result_val rises at edge 4; Q=3, R=2; operands_rdy=0 from edge 0 until consumption.
- A=3, B=7 → result_val at edge 1; Q=0, R=3. A=0, B=9 → result_val at edge 1; Q=0, R=0.
- A=16'hFFFF, B=1 → result_val at edge 65536; Q=16'hFFFF, R=0, no wrap.
- A=42, B=0 → result_val at edge 0; Q=16'hFFFF, R=42; divzero=1 when enabled. A following A=10, B=2 → Q=5, R=0, divzero=0.
- A=20, B=6: hold result_rdy=0 for 10 cycles in DONE → Q=3 and R=2 stable, operands_rdy=0, new operands_val ignored. Assert result_rdy → IDLE the next cycle.
- A=100, B=3, assert reset at edge 5 (mid-CALC) → after the reset edge: result_val=0, operands_rdy=1, Q=0, R=0. A new A=7, B=2 then yields Q=3, R=1.
